// File: rtl/md_countdown_bcd_2digit.sv
// Two-digit BCD countdown timer: parallel load, start/pause, terminal-count pulse.
// Define MD_COUNTDOWN_AUTO_RELOAD_EN to reload PRESET on reaching 00 and keep running.
module md_countdown_bcd_2digit #(
  parameter logic [7:0] PRESET = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] count,
  output logic       running,
  output logic       zero,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state;

  logic [7:0] load_clamped;
  logic [7:0] dec_val;
  logic [1:0] borrow;
  logic       dec_zero;

  assign borrow[0] = 1'b1;

  // Per-digit clamp of the load value and borrow-chained decrement.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      assign load_clamped[gi*4 +: 4] =
        (load_val[gi*4 +: 4] > 4'd9) ? 4'd9 : load_val[gi*4 +: 4];
      assign dec_val[gi*4 +: 4] =
        !borrow[gi]                 ? count[gi*4 +: 4] :
        (count[gi*4 +: 4] == 4'd0)  ? 4'd9 : (count[gi*4 +: 4] - 4'd1);
      if (gi < 1) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] & (count[gi*4 +: 4] == 4'd0);
      end
    end
  endgenerate

  assign dec_zero = (dec_val == 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= PRESET;
      running <= 1'b0;
      done    <= 1'b0;
      zero    <= (PRESET == 8'h00);
    end else begin
      done <= 1'b0;
      if (load) begin
        count   <= load_clamped;
        zero    <= (load_clamped == 8'h00);
        state   <= IDLE;
        running <= 1'b0;
      end else if (pause) begin
        // A coincident start is swallowed here; only a running count is suspended.
        if (state == RUN || state == PAUSE) begin
          state   <= PAUSE;
          running <= 1'b0;
        end
      end else if (start && state != RUN) begin
        if (state == PAUSE || count != 8'h00) begin
          state   <= RUN;
          running <= 1'b1;
        end
      end else if (tick && state == RUN) begin
        if (dec_zero) begin
          done <= 1'b1;
`ifdef MD_COUNTDOWN_AUTO_RELOAD_EN
          count <= PRESET;
          zero  <= (PRESET == 8'h00);
`else
          count   <= 8'h00;
          zero    <= 1'b1;
          state   <= DONE;
          running <= 1'b0;
`endif
        end else begin
          count <= dec_val;
          zero  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_md_countdown_bcd_2digit.sv
// Vector-table bench for md_countdown_bcd_2digit with an expected-output scoreboard.
module tb_md_countdown_bcd_2digit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] count;
  logic       running;
  logic       zero;
  logic       done;

  int tests  = 0;
  int failed = 0;

  md_countdown_bcd_2digit dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .count    (count),
    .running  (running),
    .zero     (zero),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       st;
    logic       pa;
    logic       tk;
    logic [7:0] ec;
    logic       er;
    logic       ez;
    logic       ed;
  } vec_t;

  typedef struct packed {
    logic [7:0] c;
    logic       r;
    logic       z;
    logic       d;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  task automatic add(input logic ld, input logic [7:0] lv, input logic st,
                     input logic pa, input logic tk, input logic [7:0] ec,
                     input logic er, input logic ez, input logic ed);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.pa = pa; v.tk = tk;
    v.ec = ec; v.er = er; v.ez = ez; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic expect_now(input logic [7:0] ec, input logic er,
                            input logic ez, input logic ed);
    exp_t e;
    e.c = ec; e.r = er; e.z = ez; e.d = ed;
    sb_q.push_back(e);
  endtask

  task automatic check(input string nm);
    exp_t e;
    if (sb_q.size() == 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb_q.pop_front();
      tests++;
      if (count !== e.c || running !== e.r || zero !== e.z || done !== e.d) begin
        failed++;
        $display("[TB] FAIL %s: got count=%h running=%b zero=%b done=%b, want count=%h running=%b zero=%b done=%b",
                 nm, count, running, zero, done, e.c, e.r, e.z, e.d);
      end else begin
        $display("[TB] ok %s: count=%h running=%b zero=%b done=%b", nm, count, running, zero, done);
      end
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    load = v.ld; load_val = v.lv; start = v.st; pause = v.pa; tick = v.tk;
    expect_now(v.ec, v.er, v.ez, v.ed);
    @(posedge clk);
    #1;
    check(nm);
  endtask

  task automatic idle_inputs();
    load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    //    ld lv     st pa tk  count  r  z  d
    add(0, 8'h00, 1, 0, 0, 8'h59, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h58, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h57, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h56, 1, 0, 0);
    add(1, 8'h10, 0, 0, 0, 8'h10, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h10, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h09, 1, 0, 0);
    add(1, 8'h02, 0, 0, 0, 8'h02, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h02, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0);
`ifdef MD_COUNTDOWN_AUTO_RELOAD_EN
    add(0, 8'h00, 0, 0, 1, 8'h59, 1, 0, 1);
    add(0, 8'h00, 0, 0, 0, 8'h59, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h58, 1, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h58, 1, 0, 0);
`else
    add(0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 1);
    add(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0);
`endif
    add(1, 8'h05, 0, 0, 0, 8'h05, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h05, 1, 0, 0);
    add(0, 8'h00, 0, 1, 0, 8'h05, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h05, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h05, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h05, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h04, 1, 0, 0);
    add(1, 8'h07, 1, 0, 1, 8'h07, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h07, 0, 0, 0);
    add(1, 8'hFA, 0, 0, 0, 8'h99, 0, 0, 0);
    add(1, 8'hA3, 0, 0, 0, 8'h93, 0, 0, 0);
    add(1, 8'h3F, 0, 0, 0, 8'h39, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0);
    add(1, 8'h20, 0, 0, 0, 8'h20, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 8'h20, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h19, 1, 0, 0);
    add(0, 8'h00, 1, 1, 0, 8'h19, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h19, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h19, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h18, 1, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expect_now(8'h59, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset_state");

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-count must clear outputs without waiting for a clock edge.
    @(negedge clk);
    idle_inputs();
    load = 1'b1; load_val = 8'h42;
    @(negedge clk);
    idle_inputs();
    start = 1'b1;
    @(negedge clk);
    idle_inputs();
    tick = 1'b1;
    expect_now(8'h41, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_run");
    #2;
    rst = 1'b1;
    expect_now(8'h59, 1'b0, 1'b0, 1'b0);
    #1;
    check("async_reset");
    @(negedge clk);
    rst = 1'b0;
    tick = 1'b1;
    expect_now(8'h59, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("post_reset_tick_ignored");

`ifdef MD_COUNTDOWN_AUTO_RELOAD_EN
    hv = '{ld:1'b1, lv:8'h01, st:1'b0, pa:1'b0, tk:1'b0, ec:8'h01, er:1'b0, ez:1'b0, ed:1'b0};
    apply(hv, "ar_load01");
    hv = '{ld:1'b0, lv:8'h00, st:1'b1, pa:1'b0, tk:1'b0, ec:8'h01, er:1'b1, ez:1'b0, ed:1'b0};
    apply(hv, "ar_start");
    hv = '{ld:1'b0, lv:8'h00, st:1'b0, pa:1'b0, tk:1'b1, ec:8'h59, er:1'b1, ez:1'b0, ed:1'b1};
    apply(hv, "ar_reload");
    hv = '{ld:1'b0, lv:8'h00, st:1'b0, pa:1'b0, tk:1'b0, ec:8'h59, er:1'b1, ez:1'b0, ed:1'b0};
    apply(hv, "ar_done_clears");
`else
    // Terminal sequence from 01: single-cycle done, then 00 holds.
    hv = '{ld:1'b1, lv:8'h01, st:1'b0, pa:1'b0, tk:1'b0, ec:8'h01, er:1'b0, ez:1'b0, ed:1'b0};
    apply(hv, "term_load01");
    hv = '{ld:1'b0, lv:8'h00, st:1'b1, pa:1'b0, tk:1'b0, ec:8'h01, er:1'b1, ez:1'b0, ed:1'b0};
    apply(hv, "term_start");
    hv = '{ld:1'b0, lv:8'h00, st:1'b0, pa:1'b0, tk:1'b1, ec:8'h00, er:1'b0, ez:1'b1, ed:1'b1};
    apply(hv, "term_reach00");
    hv = '{ld:1'b0, lv:8'h00, st:1'b0, pa:1'b0, tk:1'b1, ec:8'h00, er:1'b0, ez:1'b1, ed:1'b0};
    apply(hv, "term_hold00");
`endif

    @(negedge clk);
    idle_inputs();
    if (sb_q.size() != 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
